// File: rtl/nv_sink_obs_arb.sv
// Round-robin funnel: NREQ valid/ready requesters share one registered sink port,
// with a fixed dwell gap after each sink handshake.
module nv_sink_obs_arb #(
    parameter  int NREQ  = 4,
    parameter  int DW    = 8,
    parameter  int DWELL = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 sink_valid,
    output logic [DW-1:0]        sink_data,
    output logic [IDW-1:0]       sink_id,
    input  logic                 sink_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DWELL} state_e;

    localparam logic [IDW-1:0] LAST_RST   = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W     = (IDW + 1)'(NREQ);
    localparam logic [3:0]     DWELL_INIT = (DWELL == 0) ? 4'd0 : 4'(DWELL - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [DW-1:0]  data_q, data_d;
    logic [IDW-1:0] id_q, id_d;

    logic [IDW-1:0] win;
    logic           found;
    logic [IDW:0]   sum;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, last_q} + (IDW + 1)'(i);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        id_d      = id_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                // Grant is masked during reset so nothing is accepted and then lost.
                if (found && !nvdla_core_rst) begin
                    req_ready[win] = 1'b1;
                    state_d        = ST_SEND;
                    last_d         = win;
                    data_d         = req_data[win*DW +: DW];
                    id_d           = win;
                end
            end
            ST_SEND: begin
                if (sink_ready) begin
                    if (DWELL == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DWELL;
                        cnt_d   = DWELL_INIT;
                    end
                end
            end
            ST_DWELL: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign sink_valid = (state_q == ST_SEND);
    assign busy       = (state_q != ST_IDLE);
    assign sink_data  = data_q;
    assign sink_id    = id_q;

endmodule
